// File: rtl/rptr_empty_lvl_if.sv
// rptr_empty_lvl_if: read-side bus between the FIFO reader and the read-pointer manager.
//   master: reader side, drives rinc/rq2_wptr/ae_thresh/uflow_clr, observes status and RAM controls.
//   slave : rptr_empty_lvl side.
//   rvalid exists only when RPTR_FWFT_EN is defined.
interface rptr_empty_lvl_if #(parameter int ADDR_SIZE = 4);
    logic                 rinc;
    logic [ADDR_SIZE:0]   rq2_wptr;
    logic [ADDR_SIZE:0]   ae_thresh;
    logic                 uflow_clr;
    logic                 rempty;
    logic                 raempty;
    logic [ADDR_SIZE-1:0] raddr;
    logic                 ren;
    logic [ADDR_SIZE:0]   rptr;
    logic [ADDR_SIZE:0]   rlevel;
    logic                 ruflow;
`ifdef RPTR_FWFT_EN
    logic                 rvalid;
`endif
    modport master (
`ifdef RPTR_FWFT_EN
        input  rvalid,
`endif
        output rinc, rq2_wptr, ae_thresh, uflow_clr,
        input  rempty, raempty, raddr, ren, rptr, rlevel, ruflow
    );
    modport slave (
`ifdef RPTR_FWFT_EN
        output rvalid,
`endif
        input  rinc, rq2_wptr, ae_thresh, uflow_clr,
        output rempty, raempty, raddr, ren, rptr, rlevel, ruflow
    );
endinterface

// File: rtl/rptr_empty_lvl.sv
// rptr_empty_lvl: async-FIFO read pointer manager in the rclk domain.
//   rclk, rrst_n (async, active-low) : clock and reset
//   bus (slave)  : rinc, rq2_wptr (synchronised gray wptr), ae_thresh, uflow_clr in;
//                  rempty, raempty, raddr, ren, rptr (gray), rlevel, ruflow out.
//   Optional: define RPTR_FWFT_EN for first-word-fall-through prefetch (adds bus.rvalid).
module rptr_empty_lvl #(
    parameter int ADDR_SIZE = 4
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    rptr_empty_lvl_if.slave        bus
);
    logic [ADDR_SIZE:0] rbin, rbin_next, rgray, rgray_next, wbin, level_next, rlevel;
    logic               rempty, raempty, ruflow, ren, uflow_set;

`ifdef RPTR_FWFT_EN
    logic rvalid;
    // Fetch whenever the output holding slot is free or being consumed this cycle.
    assign ren       = (~rvalid | bus.rinc) & ~rempty;
    assign uflow_set = bus.rinc & ~rvalid;
    assign bus.rvalid = rvalid;
`else
    assign ren       = bus.rinc & ~rempty;
    assign uflow_set = bus.rinc & rempty;
`endif

    assign rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, ren};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign level_next = wbin - rbin_next;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++)
            wbin[i] = ^(bus.rq2_wptr >> i);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rgray   <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rlevel  <= '0;
            ruflow  <= 1'b0;
        end else begin
            rbin    <= rbin_next;
            rgray   <= rgray_next;
            rempty  <= rgray_next == bus.rq2_wptr;
            raempty <= level_next <= bus.ae_thresh;
            rlevel  <= level_next;
            ruflow  <= uflow_set | (ruflow & ~bus.uflow_clr);
        end
    end

`ifdef RPTR_FWFT_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)
            rvalid <= 1'b0;
        else
            rvalid <= ren | (rvalid & ~bus.rinc);
    end
`endif

    assign bus.ren     = ren;
    assign bus.raddr   = rbin[ADDR_SIZE-1:0];
    assign bus.rptr    = rgray;
    assign bus.rempty  = rempty;
    assign bus.raempty = raempty;
    assign bus.rlevel  = rlevel;
    assign bus.ruflow  = ruflow;
endmodule

// File: tb/tb_rptr_empty_lvl.sv
// tb_rptr_empty_lvl: randomized and directed bench for rptr_empty_lvl against a word-count model.
module tb_rptr_empty_lvl;
    localparam int A = 4;
    localparam int P = A + 1;
    localparam int DEPTH = 1 << A;

    logic rclk = 1'b0;
    logic rrst_n = 1'b0;

    rptr_empty_lvl_if #(.ADDR_SIZE(A)) bus ();
    rptr_empty_lvl #(.ADDR_SIZE(A)) dut (.rclk(rclk), .rrst_n(rrst_n), .bus(bus));

    always #5 rclk = ~rclk;

    int checks = 0;
    int failures = 0;
    // Model: total words written (as seen via rq2_wptr), total words taken from memory,
    // registered memory level, sticky underflow, and the FWFT holding-slot flag.
    int wr = 0;
    int rd = 0;
    int m_level = 0;
    bit m_uflow = 1'b0;
    bit m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [P-1:0] gray(input int n);
        logic [P-1:0] b;
        b = n[P-1:0];
        return b ^ (b >> 1);
    endfunction

    task automatic step(input bit inc, input bit clr, input int th);
        bit pop, set;
        @(negedge rclk);
        bus.rinc      = inc;
        bus.uflow_clr = clr;
        bus.ae_thresh = th[P-1:0];
        bus.rq2_wptr  = gray(wr);
`ifdef RPTR_FWFT_EN
        pop = (!m_valid || inc) && m_level != 0;
        set = inc && !m_valid;
`else
        pop = inc && m_level != 0;
        set = inc && m_level == 0;
`endif
        #1;
        check("ren", bus.ren, pop);
        check("raddr", bus.raddr, rd % DEPTH);
        check("rptr_pre", bus.rptr, gray(rd));
        rd += int'(pop);
`ifdef RPTR_FWFT_EN
        m_valid = pop || (m_valid && !inc);
`endif
        m_level = wr - rd;
        m_uflow = set || (m_uflow && !clr);
        @(posedge rclk);
        #1;
        check("rempty", bus.rempty, m_level == 0);
        check("raempty", bus.raempty, m_level <= th);
        check("rlevel", bus.rlevel, m_level);
        check("ruflow", bus.ruflow, m_uflow);
        check("rptr", bus.rptr, gray(rd));
`ifdef RPTR_FWFT_EN
        check("rvalid", bus.rvalid, m_valid);
`endif
        bus.rinc      = 1'b0;
        bus.uflow_clr = 1'b0;
    endtask

    task automatic model_reset();
        wr = 0;
        rd = 0;
        m_level = 0;
        m_uflow = 1'b0;
        m_valid = 1'b0;
        bus.rq2_wptr = '0;
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst_n = 1'b0;
        model_reset();
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rempty"}, bus.rempty, 1);
        check({tag, "_raempty"}, bus.raempty, 1);
        check({tag, "_rptr"}, bus.rptr, 0);
        check({tag, "_raddr"}, bus.raddr, 0);
        check({tag, "_rlevel"}, bus.rlevel, 0);
        check({tag, "_ruflow"}, bus.ruflow, 0);
        check({tag, "_ren"}, bus.ren, 0);
    endtask

    initial begin
        bus.rinc      = 1'b0;
        bus.uflow_clr = 1'b0;
        bus.ae_thresh = '0;
        bus.rq2_wptr  = '0;
        repeat (2) @(negedge rclk);
        #1;
        check_reset_vals("rst0");
        @(negedge rclk);
        rrst_n = 1'b1;

        // Fill level 5 with threshold 2, then drain in two bursts.
        wr = 5;
        step(0, 0, 2);
`ifndef RPTR_FWFT_EN
        check("lvl5", bus.rlevel, 5);
        check("lvl5_ae", bus.raempty, 0);
        repeat (3) step(1, 0, 2);
        check("lvl2", bus.rlevel, 2);
        check("lvl2_ae", bus.raempty, 1);
        repeat (2) step(1, 0, 2);
        check("drain_empty", bus.rempty, 1);
        check("drain_rptr", bus.rptr, 5'b00111);
`else
        repeat (6) step(1, 0, 2);
`endif

        // Completely full from pointer 0, then drain all 16 words.
        do_reset();
        wr = DEPTH;
        step(0, 0, 0);
        check("full_lvl", bus.rlevel, DEPTH);
        check("full_empty", bus.rempty, 0);
        repeat (DEPTH) step(1, 0, 0);
`ifndef RPTR_FWFT_EN
        check("full_drained", bus.rempty, 1);
        check("full_rptr", bus.rptr, 5'b11000);
`else
        repeat (2) step(1, 0, 0);
`endif

        // Underflow: set, set-beats-clear, clear.
        step(1, 0, 0);
        check("uflow_set", bus.ruflow, 1);
        step(1, 1, 0);
        check("uflow_win", bus.ruflow, 1);
        step(0, 1, 0);
        check("uflow_clr", bus.ruflow, 0);

        // Asynchronous reset in the middle of traffic with level 7.
        wr = rd + 7;
        step(0, 0, 3);
        check("pre_arst_lvl", bus.rlevel, 7);
        step(1, 0, 3);
        @(negedge rclk);
        #2;
        rrst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        model_reset();
        @(negedge rclk);
        rrst_n = 1'b1;

        // Random streaming across many pointer wraps.
        for (int n = 0; n < 800; n++) begin
            int room;
            room = DEPTH - (wr - rd);
            wr += int'($urandom_range(0, room < 3 ? room : 3));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), int'($urandom_range(0, DEPTH)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rptr_empty_lvl.md
Name: rptr_empty_lvl

Overview:
Read-side pointer manager for the async FIFO, in the rclk domain. Keeps a binary and a gray read pointer, produces the RAM read address/enable and the empty flag. Converts the synchronised gray write pointer to binary to report fill level, a programmable almost-empty flag and a sticky underflow flag. Optionally provides first-word-fall-through (FWFT) prefetch.

Parameters:
ADDR_SIZE, 4, RAM address width; FIFO depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.

Ports:
rclk  in  1  read clock
rrst_n  in  1  asynchronous active-low reset
rinc  in  1  read request / consume
rq2_wptr  in  ADDR_SIZE+1  gray write pointer, already 2-flop synchronised to rclk
ae_thresh  in  ADDR_SIZE+1  almost-empty threshold, quasi-static
uflow_clr  in  1  clears ruflow
rempty  out  1  FIFO memory empty (registered)
raempty  out  1  almost empty (registered)
raddr  out  ADDR_SIZE  RAM read address
ren  out  1  RAM read enable (combinational)
rptr  out  ADDR_SIZE+1  gray read pointer to write domain (registered)
rlevel  out  ADDR_SIZE+1  words in memory, 0..2**ADDR_SIZE (registered)
ruflow  out  1  sticky underflow (registered)

Behaviour:
- Reset (rrst_n=0, async, takes effect immediately with no clock edge): rbin=0, rptr=0, rempty=1, raempty=1, rlevel=0, ruflow=0; raddr=0 and ren=0 follow from this.
- ren = rinc & ~rempty. rbin_next = rbin + ren, modulo 2**(ADDR_SIZE+1). rgray_next = (rbin_next>>1) ^ rbin_next.
- Each rclk: rbin<=rbin_next, rptr<=rgray_next. raddr = rbin[ADDR_SIZE-1:0].
- rempty <= (rgray_next == rq2_wptr).
- wbin = gray2bin(rq2_wptr), combinational. level_next = wbin - rbin_next, modulo 2**(ADDR_SIZE+1). rlevel <= level_next.
- rlevel==0 exactly when rempty==1, since both come from the same rq2_wptr sample.
- raempty <= (level_next <= ae_thresh). With ae_thresh=0, raempty equals rempty.
- ruflow: set when rinc & rempty; cleared by uflow_clr. If set and clear coincide, set wins. Holds otherwise.
- Read while empty: pointer frozen, ren=0, only ruflow changes.
- Wrap-around: rbin rolls over from 2**(ADDR_SIZE+1)-1 to 0 with no special handling. The extra MSB disambiguates full from empty, so level 2**ADDR_SIZE is representable.
- Latency: rempty/rlevel/raempty reflect a rq2_wptr change one rclk later; the write domain sees rptr one rclk after the read.
- rq2_wptr is guaranteed valid gray with level <= depth; no checking or clamping.

Optional Feature:
RPTR_FWFT_EN
- Defined: adds output rvalid (1 bit, reset 0). The RAM has registered read data; the block prefetches so the head word is presented without a request.
- FWFT ren = (~rvalid | rinc) & ~rempty.
- FWFT rvalid <= ren | (rvalid & ~rinc).
- rinc means "consume presented word". rinc with rvalid=0 is ignored and sets ruflow; the ruflow set condition becomes rinc & ~rvalid.
- rinc & rvalid with rempty=1: rvalid drops to 0 next cycle.
- rlevel and raempty count memory contents only, excluding the held word.
- Undefined: no rvalid port; behaviour exactly as above.

Test Plan:
- Assert rrst_n=0 mid-traffic with rlevel=7 -> all outputs return to reset values immediately, without an rclk edge: rempty=1, raempty=1, rptr=0, raddr=0, rlevel=0, ruflow=0.
- ADDR_SIZE=4, ae_thresh=2, rq2_wptr=5'b00111 (gray 5), no reads -> next cycle rempty=0, rlevel=5, raempty=0. Then 3 reads -> rlevel=2, raempty=1. Then 2 reads -> rempty=1, rlevel=0, rptr=5'b00111.
- rptr=0, rq2_wptr=5'b11000 (gray 16) -> rlevel=16, rempty=0, raempty=0. Then 16 reads -> rempty=1, rbin=16.
- Stream 40 words with the write pointer advancing in step; rbin passes 31->0 -> rempty only when rptr==rq2_wptr, rlevel never exceeds 16, raddr sequence continuous mod 16.
- rempty=1: rinc=1 -> ren=0, rptr unchanged, ruflow=1 next cycle. Then rinc=1 with uflow_clr=1 -> ruflow stays 1. Then uflow_clr alone -> ruflow=0.
- RPTR_FWFT_EN, rq2_wptr goes from 0 to gray 2 with rinc=0 -> ren pulses once, rvalid=1 next cycle, rlevel=1. Then rinc held 2 cycles -> second word presented, then rvalid=0, rempty=1, ruflow=0.
